// File: rtl/base58_pkg.sv
// Shared constants, types and helpers for the base-58 sequential encoder.
//   RADIX              divisor used by the bit-serial divider
//   OFS_*              ASCII offsets for the contiguous 0-9,A-Z,a-v alphabet
//   BTC_ALPHABET       Bitcoin base-58 alphabet, 58 x 8-bit entries, first char = digit 0
//   state_e            encoder FSM states
//   cnt_w / len_w      width helpers for the bit counter and digit index/length
package base58_pkg;

    localparam int unsigned RADIX     = 58;
    localparam int unsigned OFS_DIGIT = 48;
    localparam int unsigned OFS_UPPER = 55;
    localparam int unsigned OFS_LOWER = 61;

    // Packed string: the first character sits in the most significant byte.
    localparam logic [8*58-1:0] BTC_ALPHABET =
        "123456789ABCDEFGHJKLMNPQRSTUVWXYZabcdefghijkmnopqrstuvwxyz";

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_e;

    // Width of a counter that must hold values 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a field that must hold values 0..digits.
    function automatic int unsigned len_w(input int unsigned digits);
        return $clog2(digits + 1);
    endfunction

    function automatic logic [7:0] btc_char(input logic [5:0] d);
        int idx;
        if (d > 6'd57) begin
            return 8'h00;
        end
        idx = 57 - int'(d);
        return BTC_ALPHABET[8*idx +: 8];
    endfunction

endpackage

// File: rtl/base58_char_map.sv
// Combinational base-58 digit to ASCII mapper.
//   i_digit  [5:0]  digit value 0..57
//   o_ascii  [7:0]  ASCII character for the selected alphabet
//   ALPHABET        0: 0-9,A-Z,a-v   1: Bitcoin alphabet
module base58_char_map
    import base58_pkg::*;
#(
    parameter int unsigned ALPHABET = 0
) (
    input  logic [5:0] i_digit,
    output logic [7:0] o_ascii
);

    logic [7:0] w_digit8;
    assign w_digit8 = {2'b00, i_digit};

    always_comb begin
        o_ascii = 8'h00;
        if (ALPHABET == 1) begin
            o_ascii = btc_char(i_digit);
        end else if (i_digit < 6'd10) begin
            o_ascii = w_digit8 + 8'(OFS_DIGIT);
        end else if (i_digit < 6'd36) begin
            o_ascii = w_digit8 + 8'(OFS_UPPER);
        end else begin
            o_ascii = w_digit8 + 8'(OFS_LOWER);
        end
    end

endmodule

// File: rtl/base58_seq_encoder.sv
// Sequential binary to base-58 ASCII encoder using a bit-serial restoring divide-by-58.
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_in_valid/o_in_ready/i_in_data   input word handshake (ready only in IDLE)
//   o_out_valid/i_out_ready           result handshake, result held until accepted
//   o_out_chars        DIGITS ASCII chars, [7:0] = least-significant digit
//   o_out_len          index of highest nonzero digit + 1 (1 for zero)
//   o_out_ovf          value did not fit into DIGITS digits
module base58_seq_encoder
    import base58_pkg::*;
#(
    parameter int unsigned IN_W     = 32,
    parameter int unsigned DIGITS   = 6,
    parameter int unsigned ALPHABET = 0,
    localparam int unsigned LEN_W   = len_w(DIGITS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [IN_W-1:0]       i_in_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [8*DIGITS-1:0]   o_out_chars,
    output logic [LEN_W-1:0]      o_out_len,
    output logic                  o_out_ovf
);

    localparam int unsigned CNT_W = cnt_w(IN_W);

    state_e                r_state;
    state_e                w_state_next;
    logic [IN_W-1:0]       r_work;
    logic [5:0]            r_rem;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [LEN_W-1:0]      r_dig_idx;
    logic [8*DIGITS-1:0]   r_chars;
    logic [LEN_W-1:0]      r_len;
    logic                  r_ovf;
    logic                  r_out_valid;

    logic [6:0]            w_trial;
    logic                  w_qbit;
    logic [5:0]            w_rem_next;
    logic                  w_last_bit;
    logic                  w_digits_done;
    logic [7:0]            w_char;

    // One restoring-division step: shift the next dividend bit into the remainder.
    assign w_trial       = {r_rem, r_work[IN_W-1]};
    assign w_qbit        = (w_trial >= 7'(RADIX));
    assign w_rem_next    = w_qbit ? 6'(w_trial - 7'(RADIX)) : w_trial[5:0];
    assign w_last_bit    = (r_bit_cnt == '0);
    assign w_digits_done = (r_dig_idx == LEN_W'(DIGITS));

    base58_char_map #(
        .ALPHABET (ALPHABET)
    ) u_char_map (
        .i_digit (w_rem_next),
        .o_ascii (w_char)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_in_valid)    w_state_next = DIV;
            DIV:     if (w_digits_done) w_state_next = DONE;
            DONE:    if (i_out_ready)   w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_work      <= '0;
            r_rem       <= '0;
            r_bit_cnt   <= '0;
            r_dig_idx   <= '0;
            r_chars     <= '0;
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_work    <= i_in_data;
                        r_rem     <= '0;
                        r_bit_cnt <= CNT_W'(IN_W - 1);
                        r_dig_idx <= '0;
                        r_len     <= LEN_W'(1);
                        r_ovf     <= 1'b0;
                    end
                end
                DIV: begin
                    if (!w_digits_done) begin
                        // Quotient bits replace the consumed dividend bits from the bottom.
                        r_work <= {r_work[IN_W-2:0], w_qbit};
                        if (w_last_bit) begin
                            for (int i = 0; i < int'(DIGITS); i++) begin
                                if (r_dig_idx == LEN_W'(i)) begin
                                    r_chars[8*i +: 8] <= w_char;
                                end
                            end
                            if (w_rem_next != 6'd0) begin
                                r_len <= r_dig_idx + LEN_W'(1);
                            end
                            r_rem     <= '0;
                            r_bit_cnt <= CNT_W'(IN_W - 1);
                            r_dig_idx <= r_dig_idx + LEN_W'(1);
                        end else begin
                            r_rem     <= w_rem_next;
                            r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                        end
                    end else begin
                        // Anything left in the quotient means the value needs more digits.
                        r_ovf       <= |r_work;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_chars = r_chars;
    assign o_out_len   = r_len;
    assign o_out_ovf   = r_ovf;

endmodule

// File: tb/tb_base58_seq_encoder.sv
module tb_base58_seq_encoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_chars;
    logic [2:0]  out_len;
    logic        out_ovf;

    // Bitcoin-alphabet instance shares the main input stream.
    logic        b_in_ready;
    logic        b_out_valid;
    logic [47:0] b_out_chars;
    logic [2:0]  b_out_len;
    logic        b_out_ovf;

    // Two-digit instance with its own handshake.
    logic        d2_in_valid;
    logic        d2_in_ready;
    logic [31:0] d2_in_data;
    logic        d2_out_valid;
    logic        d2_out_ready;
    logic [15:0] d2_out_chars;
    logic [1:0]  d2_out_len;
    logic        d2_out_ovf;

    base58_seq_encoder #(.IN_W(32), .DIGITS(6), .ALPHABET(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_data(in_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_chars(out_chars), .o_out_len(out_len), .o_out_ovf(out_ovf)
    );

    base58_seq_encoder #(.IN_W(32), .DIGITS(6), .ALPHABET(1)) dut_btc (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(b_in_ready),
        .i_in_data(in_data), .o_out_valid(b_out_valid), .i_out_ready(out_ready),
        .o_out_chars(b_out_chars), .o_out_len(b_out_len), .o_out_ovf(b_out_ovf)
    );

    base58_seq_encoder #(.IN_W(32), .DIGITS(2), .ALPHABET(0)) dut_d2 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(d2_in_valid), .o_in_ready(d2_in_ready),
        .i_in_data(d2_in_data), .o_out_valid(d2_out_valid), .i_out_ready(d2_out_ready),
        .o_out_chars(d2_out_chars), .o_out_len(d2_out_len), .o_out_ovf(d2_out_ovf)
    );

    typedef struct {
        logic [31:0] data;
        logic [47:0] chars;
        logic [2:0]  len;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Present a word, wait for acceptance, then count clock edges until out_valid.
    task automatic send(input logic [31:0] d, output int lat);
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        guard    = 0;
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic retire(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_in_ready_after"}, 64'(in_ready), 64'd1);
        chk({name, "_out_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        logic [47:0] held;

        vecs[0] = '{32'd0,          "000000", 3'd1, 1'b0};
        vecs[1] = '{32'd57,         "00000v", 3'd1, 1'b0};
        vecs[2] = '{32'd58,         "000010", 3'd2, 1'b0};
        vecs[3] = '{32'd255,        "00004N", 3'd2, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF,  "6VUm8F", 3'd6, 1'b0};
        vecs[5] = '{32'd3364,       "000100", 3'd3, 1'b0};

        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        d2_in_valid  = 1'b0;
        d2_in_data   = '0;
        d2_out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_chars", 64'(out_chars), 64'd0);
        chk("rst_len", 64'(out_len), 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, lat);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd193);
            chk($sformatf("v%0d_chars", i), 64'(out_chars), 64'(vecs[i].chars));
            chk($sformatf("v%0d_len", i), 64'(out_len), 64'(vecs[i].len));
            chk($sformatf("v%0d_ovf", i), 64'(out_ovf), 64'(vecs[i].ovf));
            if (vecs[i].data == 32'd58) begin
                chk("btc_58_chars", 64'(b_out_chars), 64'("111121"));
                chk("btc_58_len", 64'(b_out_len), 64'd2);
            end
            retire($sformatf("v%0d", i));
        end

        // Stall: result must hold and new input must be ignored.
        send(32'd255, lat);
        chk("stall_latency", 64'(lat), 64'd193);
        held = out_chars;
        chk("stall_first_chars", 64'(held), 64'("00004N"));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h1234_5678;
            chk($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
            chk($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
            chk($sformatf("stall%0d_chars", c), 64'(out_chars), 64'("00004N"));
        end
        chk("stall_len", 64'(out_len), 64'd2);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("stall_release_in_ready", 64'(in_ready), 64'd1);
        chk("stall_release_valid", 64'(out_valid), 64'd0);

        // Reset during the fourth digit discards the conversion.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3 * 32 + 5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_chars", 64'(out_chars), 64'd0);
        chk("midrst_len", 64'(out_len), 64'd0);
        chk("midrst_ovf", 64'(out_ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send(32'd255, lat);
        chk("postrst_latency", 64'(lat), 64'd193);
        chk("postrst_chars", 64'(out_chars), 64'("00004N"));
        chk("postrst_len", 64'(out_len), 64'd2);
        retire("postrst");

        // Two-digit encoder: 58^2 overflows with both digits zero.
        @(negedge clk);
        d2_in_valid = 1'b1;
        d2_in_data  = 32'd3364;
        chk("d2_in_ready", 64'(d2_in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        d2_in_valid = 1'b0;
        lat = 0;
        while (lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
            if (d2_out_valid) break;
        end
        chk("d2_latency", 64'(lat), 64'd65);
        chk("d2_ovf", 64'(d2_out_ovf), 64'd1);
        chk("d2_chars", 64'(d2_out_chars), 64'("00"));
        chk("d2_len", 64'(d2_out_len), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
